serial_add_sub: RTL and testbench

Parametrised bit-serial adder/subtractor. It reuses a single full-adder cell and a carry flip-flop across WIDTH clock cycles to add or subtract two WIDTH-bit operands. It is the sequential successor to the lab's one-bit full adder, and adds a start/busy/done handshake, a subtract mode, unsigned carry/borrow reporting and signed overflow. It sits between operand registers (switches/buttons) and the display/LED datapath.

---
 rtl/serial_add_sub_if.sv | 36 +++
 rtl/serial_add_sub.sv | 132 +++++++++++++
 tb/tb_serial_add_sub.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/serial_add_sub_if.sv
// -----------------------------------------------------------------------------
// serial_add_sub_if
// Handshake and operand/result bundle for the bit-serial adder/subtractor.
//   START  request, sampled by the datapath only while it is idle
//   SUB    mode, 0 = A+B, 1 = A-B (sampled with START)
//   A, B   WIDTH-bit operands (sampled with START)
//   BUSY   high while bits are being processed
//   DONE   one-cycle pulse when the result registers update
//   SUM    WIDTH-bit result, holds the last completed value
//   COUT   carry out of the MSB (for subtraction, 1 = no borrow)
//   OVF    two's-complement overflow of the last operation
// Modports: master = requester (drives START/SUB/A/B), slave = datapath.
// -----------------------------------------------------------------------------
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             START;
  logic             SUB;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] SUM;
  logic             COUT;
  logic             OVF;

  modport master (
    output START, SUB, A, B,
    input  BUSY, DONE, SUM, COUT, OVF
  );

  modport slave (
    input  START, SUB, A, B,
    output BUSY, DONE, SUM, COUT, OVF
  );
endinterface

// File: rtl/serial_add_sub.sv
// -----------------------------------------------------------------------------
// serial_add_sub
// Bit-serial adder/subtractor: one full-adder cell and a carry flop are reused
// over WIDTH clock cycles, LSB first. Subtraction is A + ~B + 1.
// Ports:
//   CLK  system clock, all state changes on its rising edge
//   RST  synchronous reset, active-high, highest priority
//   bus  serial_add_sub_if.slave (START/SUB/A/B in, BUSY/DONE/SUM/COUT/OVF out)
// Timing: START sampled in IDLE at edge 0, WIDTH RUN cycles, then one FIN
// cycle with DONE high; SUM/COUT/OVF update only on entry to FIN.
// -----------------------------------------------------------------------------
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic              CLK,
  input  logic              RST,
  serial_add_sub_if.slave   bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  // Holds the already-computed low bits; the MSB is merged in on the last edge.
  logic [WIDTH-2:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             s_s;
  logic             cn_s;
  logic [WIDTH-1:0] res_shift_s;

  // Full-adder cell operating on the current LSBs and the carry flop.
  always_comb begin
    s_s         = opa_q[0] ^ opb_q[0] ^ c_q;
    cn_s        = (opa_q[0] & opb_q[0]) | (opa_q[0] & c_q) | (opb_q[0] & c_q);
    res_shift_s = {s_s, res_q};
  end

  // Next-state and datapath update for the IDLE/RUN/FIN sequencer.
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          opa_d   = bus.A;
          opb_d   = bus.SUB ? ~bus.B : bus.B;
          c_d     = bus.SUB;
          cnt_d   = {CW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        opa_d = opa_q >> 1;
        opb_d = opb_q >> 1;
        res_d = res_shift_s[WIDTH-1:1];
        c_d   = cn_s;
        if (cnt_q == CNT_LAST) begin
          // c_q is the carry into the MSB; overflow is carry-in ^ carry-out there.
          sum_d   = res_shift_s;
          cout_d  = cn_s;
          ovf_d   = c_q ^ cn_s;
          cnt_d   = {CW{1'b0}};
          state_d = FIN;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      opa_q   <= {WIDTH{1'b0}};
      opb_q   <= {WIDTH{1'b0}};
      res_q   <= {(WIDTH-1){1'b0}};
      cnt_q   <= {CW{1'b0}};
      c_q     <= 1'b0;
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Handshake flags are direct decodes of the state register.
  assign bus.BUSY = (state_q == RUN);
  assign bus.DONE = (state_q == FIN);
  assign bus.SUM  = sum_q;
  assign bus.COUT = cout_q;
  assign bus.OVF  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_add_sub
// Directed bench for serial_add_sub at WIDTH = 8 and an exhaustive sweep at
// WIDTH = 3. Both instances share one clock; expected values are hand-computed
// constants or a small arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_serial_add_sub;

  logic CLK;
  logic RST;
  int   n_cmp;
  int   n_err;

  serial_add_sub_if #(.WIDTH(8)) bus8 ();
  serial_add_sub_if #(.WIDTH(3)) bus3 ();

  serial_add_sub #(.WIDTH(8)) dut8 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus8)
  );

  serial_add_sub #(.WIDTH(3)) dut3 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus3)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full 8-bit operation: BUSY for exactly 8 cycles with SUM held, then DONE.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic sub, input logic [7:0] prev,
                      input logic [7:0] e_sum, input logic e_cout, input logic e_ovf);
    bus8.A = a; bus8.B = b; bus8.SUB = sub; bus8.START = 1'b1;
    tick();
    bus8.START = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check({tag, "_busy"}, {7'd0, bus8.BUSY}, 8'd1);
      check({tag, "_nodone"}, {7'd0, bus8.DONE}, 8'd0);
      check({tag, "_hold"}, bus8.SUM, prev);
      tick();
    end
    check({tag, "_busy_end"}, {7'd0, bus8.BUSY}, 8'd0);
    check({tag, "_done"}, {7'd0, bus8.DONE}, 8'd1);
    check({tag, "_sum"}, bus8.SUM, e_sum);
    check({tag, "_cout"}, {7'd0, bus8.COUT}, {7'd0, e_cout});
    check({tag, "_ovf"}, {7'd0, bus8.OVF}, {7'd0, e_ovf});
    tick();
    check({tag, "_done_pulse"}, {7'd0, bus8.DONE}, 8'd0);
  endtask

  logic [3:0] r3;
  logic [2:0] bb3;
  logic [2:0] e3_sum;
  logic       e3_cout;
  logic       e3_ovf;

  initial begin
    n_cmp = 0;
    n_err = 0;
    RST = 1'b1;
    bus8.START = 1'b1; bus8.SUB = 1'b0; bus8.A = 8'h55; bus8.B = 8'hAA;
    bus3.START = 1'b1; bus3.SUB = 1'b0; bus3.A = 3'd1;  bus3.B = 3'd2;

    // Reset held for two cycles with START high.
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_busy", {7'd0, bus8.BUSY}, 8'd0);
      check("rst_done", {7'd0, bus8.DONE}, 8'd0);
      check("rst_sum",  bus8.SUM, 8'h00);
      check("rst_cout", {7'd0, bus8.COUT}, 8'd0);
      check("rst_ovf",  {7'd0, bus8.OVF}, 8'd0);
      check("rst3_busy", {7'd0, bus3.BUSY}, 8'd0);
    end
    bus8.START = 1'b0;
    bus3.START = 1'b0;
    RST = 1'b0;
    tick();
    check("idle_busy", {7'd0, bus8.BUSY}, 8'd0);

    run8("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h00, 8'h10, 1'b0, 1'b0);
    run8("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h10, 8'h80, 1'b0, 1'b1);
    run8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h80, 8'h00, 1'b1, 1'b0);
    run8("sub_05_07", 8'h05, 8'h07, 1'b1, 8'h00, 8'hFE, 1'b0, 1'b0);
    run8("sub_80_01", 8'h80, 8'h01, 1'b1, 8'hFE, 8'h7F, 1'b1, 1'b1);

    // Request during RUN is ignored: 10 + 20 completes unchanged.
    bus8.A = 8'h10; bus8.B = 8'h20; bus8.SUB = 1'b0; bus8.START = 1'b1;
    tick();
    bus8.START = 1'b0;
    tick();
    tick();
    bus8.A = 8'hFF; bus8.SUB = 1'b1; bus8.START = 1'b1;
    check("ign_hold", bus8.SUM, 8'h7F);
    tick();
    bus8.START = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("ign_busy", {7'd0, bus8.BUSY}, 8'd1);
      check("ign_hold2", bus8.SUM, 8'h7F);
      tick();
    end
    check("ign_done", {7'd0, bus8.DONE}, 8'd1);
    check("ign_sum", bus8.SUM, 8'h30);
    check("ign_cout", {7'd0, bus8.COUT}, 8'd0);
    check("ign_ovf", {7'd0, bus8.OVF}, 8'd0);
    tick();
    check("ign_idle", {7'd0, bus8.BUSY}, 8'd0);

    // Abort with RST at RUN cycle 4.
    bus8.A = 8'h7F; bus8.B = 8'h01; bus8.SUB = 1'b0; bus8.START = 1'b1;
    tick();
    bus8.START = 1'b0;
    tick();
    tick();
    tick();
    check("abt_busy_pre", {7'd0, bus8.BUSY}, 8'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check("abt_busy", {7'd0, bus8.BUSY}, 8'd0);
    check("abt_done", {7'd0, bus8.DONE}, 8'd0);
    check("abt_sum", bus8.SUM, 8'h00);
    check("abt_cout", {7'd0, bus8.COUT}, 8'd0);
    check("abt_ovf", {7'd0, bus8.OVF}, 8'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("abt_nodone", {7'd0, bus8.DONE}, 8'd0);
    end

    // START held high: period of WIDTH+2 cycles between operations.
    bus8.A = 8'h01; bus8.B = 8'h02; bus8.SUB = 1'b0; bus8.START = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    check("b2b_done", {7'd0, bus8.DONE}, 8'd1);
    tick();
    check("b2b_idle", {7'd0, bus8.BUSY}, 8'd0);
    tick();
    check("b2b_restart", {7'd0, bus8.BUSY}, 8'd1);
    bus8.START = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("b2b_sum", bus8.SUM, 8'h03);

    // WIDTH = 3 exhaustive sweep against an arithmetic reference.
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 8; a++) begin
        for (int b = 0; b < 8; b++) begin
          bb3     = (s == 1) ? ~3'(b) : 3'(b);
          r3      = {1'b0, 3'(a)} + {1'b0, bb3} + 4'(s);
          e3_sum  = r3[2:0];
          e3_cout = r3[3];
          e3_ovf  = (a[2] == bb3[2]) && (e3_sum[2] != a[2]);
          bus3.A = 3'(a); bus3.B = 3'(b); bus3.SUB = s[0]; bus3.START = 1'b1;
          tick();
          bus3.START = 1'b0;
          tick();
          tick();
          check("w3_early", {7'd0, bus3.DONE}, 8'd0);
          tick();
          check("w3_done", {7'd0, bus3.DONE}, 8'd1);
          check("w3_sum", {5'd0, bus3.SUM}, {5'd0, e3_sum});
          check("w3_cout", {7'd0, bus3.COUT}, {7'd0, e3_cout});
          check("w3_ovf", {7'd0, bus3.OVF}, {7'd0, e3_ovf});
          tick();
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
